// File: rtl/mor1kx_rf_port_ctrl_cappuccino_if.sv
// ---------------------------------------------------------------------------
// mor1kx_rf_port_ctrl_cappuccino_if : SPR-bus GPR access signals. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface mor1kx_rf_port_ctrl_cappuccino_if #(
  parameter int OPTION_OPERAND_WIDTH = 32
) ();
  logic [15:0]                     spr_bus_addr_i;
  logic                            spr_bus_stb_i;
  logic                            spr_bus_we_i;
  logic [OPTION_OPERAND_WIDTH-1:0] spr_bus_dat_i;
  logic                            spr_gpr_ack_o;
  logic [OPTION_OPERAND_WIDTH-1:0] spr_gpr_dat_o;

  modport master (
    output spr_bus_addr_i, spr_bus_stb_i, spr_bus_we_i, spr_bus_dat_i,
    input  spr_gpr_ack_o, spr_gpr_dat_o
  );

  modport slave (
    input  spr_bus_addr_i, spr_bus_stb_i, spr_bus_we_i, spr_bus_dat_i,
    output spr_gpr_ack_o, spr_gpr_dat_o
  );
endinterface

`default_nettype wire

// File: rtl/mor1kx_rf_port_ctrl_cappuccino.sv
// ---------------------------------------------------------------------------
// mor1kx_rf_port_ctrl_cappuccino : GPR RAM write-port arbiter / init. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mor1kx_rf_port_ctrl_cappuccino #(
  parameter int OPTION_OPERAND_WIDTH    = 32,
  parameter int RF_ADDR_WIDTH           = 5,
  parameter int OPTION_RF_CLEAR_ON_INIT = 1,
  parameter int STARVE_LIMIT            = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            wb_we_i,
  input  logic [RF_ADDR_WIDTH-1:0]        wb_adr_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] wb_dat_i,
  mor1kx_rf_port_ctrl_cappuccino_if.slave spr,
  output logic                            rf_we_o,
  output logic [RF_ADDR_WIDTH-1:0]        rf_wadr_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] rf_wdat_o,
  output logic                            rf_spr_re_o,
  output logic [RF_ADDR_WIDTH-1:0]        rf_spr_radr_o,
  input  logic [OPTION_OPERAND_WIDTH-1:0] rf_spr_rdat_i,
  output logic                            pipe_stall_o,
  output logic                            init_done_o
);

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_IDLE  = 3'd1,
    ST_WPEND = 3'd2,
    ST_RD    = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam state_t ST_RESET = (OPTION_RF_CLEAR_ON_INIT != 0) ? ST_INIT : ST_IDLE;
  localparam logic [RF_ADDR_WIDTH-1:0] INIT_LAST = {RF_ADDR_WIDTH{1'b1}};

  state_t                          state_q, state_d;
  logic [RF_ADDR_WIDTH-1:0]        init_cnt_q, init_cnt_d;
  logic [3:0]                      starve_cnt_q, starve_cnt_d;
  logic                            fwd_q, fwd_d;
  logic [OPTION_OPERAND_WIDTH-1:0] fwd_dat_q, fwd_dat_d;
  logic [RF_ADDR_WIDTH-1:0]        wbuf_adr_q, wbuf_adr_d;
  logic [OPTION_OPERAND_WIDTH-1:0] wbuf_dat_q, wbuf_dat_d;

  logic                            gpr_stb;
  logic                            gpr_ack;
  logic [OPTION_OPERAND_WIDTH-1:0] gpr_dat;
  logic                            unused_addr;

  assign gpr_stb       = spr.spr_bus_stb_i && (spr.spr_bus_addr_i[15:9] == 7'h2);
  assign rf_spr_radr_o = spr.spr_bus_addr_i[RF_ADDR_WIDTH-1:0];
  assign unused_addr   = ^spr.spr_bus_addr_i;

  assign spr.spr_gpr_ack_o = gpr_ack;
  assign spr.spr_gpr_dat_o = gpr_dat;

  assign init_done_o  = (state_q != ST_INIT);
  assign pipe_stall_o = (state_q == ST_INIT) ||
                        ((state_q == ST_WPEND) && (starve_cnt_q >= 4'(STARVE_LIMIT)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_RESET;
      init_cnt_q   <= '0;
      starve_cnt_q <= '0;
      fwd_q        <= 1'b0;
      fwd_dat_q    <= '0;
      wbuf_adr_q   <= '0;
      wbuf_dat_q   <= '0;
    end else begin
      state_q      <= state_d;
      init_cnt_q   <= init_cnt_d;
      starve_cnt_q <= starve_cnt_d;
      fwd_q        <= fwd_d;
      fwd_dat_q    <= fwd_dat_d;
      wbuf_adr_q   <= wbuf_adr_d;
      wbuf_dat_q   <= wbuf_dat_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    init_cnt_d   = init_cnt_q;
    starve_cnt_d = starve_cnt_q;
    fwd_d        = fwd_q;
    fwd_dat_d    = fwd_dat_q;
    wbuf_adr_d   = wbuf_adr_q;
    wbuf_dat_d   = wbuf_dat_q;
    rf_we_o      = wb_we_i;
    rf_wadr_o    = wb_adr_i;
    rf_wdat_o    = wb_dat_i;
    rf_spr_re_o  = 1'b0;
    gpr_ack      = 1'b0;
    gpr_dat      = '0;

    case (state_q)
      ST_INIT: begin
        rf_we_o    = 1'b1;
        rf_wadr_o  = init_cnt_q;
        rf_wdat_o  = '0;
        init_cnt_d = init_cnt_q + RF_ADDR_WIDTH'(1);
        if (init_cnt_q == INIT_LAST)
          state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (gpr_stb) begin
          if (spr.spr_bus_we_i) begin
            wbuf_adr_d   = rf_spr_radr_o;
            wbuf_dat_d   = spr.spr_bus_dat_i;
            starve_cnt_d = '0;
            state_d      = ST_WPEND;
          end else begin
            rf_spr_re_o = 1'b1;
            state_d     = ST_RD;
            // RAM read would return the old value; capture the concurrent write instead
            if (wb_we_i && (wb_adr_i == rf_spr_radr_o)) begin
              fwd_d     = 1'b1;
              fwd_dat_d = wb_dat_i;
            end
          end
        end
      end
      ST_WPEND: begin
        if (wb_we_i) begin
          if (starve_cnt_q != 4'hF)
            starve_cnt_d = starve_cnt_q + 4'd1;
        end else begin
          rf_we_o   = 1'b1;
          rf_wadr_o = wbuf_adr_q;
          rf_wdat_o = wbuf_dat_q;
          gpr_ack   = 1'b1;
          state_d   = ST_DONE;
        end
      end
      ST_RD: begin
        gpr_ack = 1'b1;
        gpr_dat = fwd_q ? fwd_dat_q : rf_spr_rdat_i;
        fwd_d   = 1'b0;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_RESET;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_mor1kx_rf_port_ctrl_cappuccino.sv
// ---------------------------------------------------------------------------
// tb_mor1kx_rf_port_ctrl_cappuccino : scoreboard bench for the RF port ctrl. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mor1kx_rf_port_ctrl_cappuccino;

  typedef struct {
    logic [4:0]  adr;
    logic [31:0] dat;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_we;
  logic [4:0]  wb_adr;
  logic [31:0] wb_dat;
  logic        rf_we;
  logic [4:0]  rf_wadr;
  logic [31:0] rf_wdat;
  logic        rf_spr_re;
  logic [4:0]  rf_spr_radr;
  logic [31:0] rf_spr_rdat;
  logic        pipe_stall;
  logic        init_done;

  int checks = 0;
  int errors = 0;

  wr_t         exp_wr_q[$];
  logic [31:0] exp_ack_q[$];

  mor1kx_rf_port_ctrl_cappuccino_if #(.OPTION_OPERAND_WIDTH(32)) spr_if ();

  mor1kx_rf_port_ctrl_cappuccino #(
    .OPTION_OPERAND_WIDTH    (32),
    .RF_ADDR_WIDTH           (5),
    .OPTION_RF_CLEAR_ON_INIT (1),
    .STARVE_LIMIT            (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .wb_we_i       (wb_we),
    .wb_adr_i      (wb_adr),
    .wb_dat_i      (wb_dat),
    .spr           (spr_if.slave),
    .rf_we_o       (rf_we),
    .rf_wadr_o     (rf_wadr),
    .rf_wdat_o     (rf_wdat),
    .rf_spr_re_o   (rf_spr_re),
    .rf_spr_radr_o (rf_spr_radr),
    .rf_spr_rdat_i (rf_spr_rdat),
    .pipe_stall_o  (pipe_stall),
    .init_done_o   (init_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_wr(input logic [4:0] adr, input logic [31:0] dat);
    wr_t e;
    e.adr = adr;
    e.dat = dat;
    exp_wr_q.push_back(e);
  endtask

  // Monitor: every write-port and ack event is matched against the scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      if (rf_we) begin
        checks++;
        if (exp_wr_q.size() == 0) begin
          errors++;
          $display("FAIL wr_unexpected got adr %0d dat %h expected none at %0t", rf_wadr, rf_wdat, $time);
        end else begin
          wr_t e;
          e = exp_wr_q.pop_front();
          if (rf_wadr !== e.adr || rf_wdat !== e.dat) begin
            errors++;
            $display("FAIL wr_port got adr %0d dat %h expected adr %0d dat %h at %0t",
                     rf_wadr, rf_wdat, e.adr, e.dat, $time);
          end
        end
      end
      if (spr_if.spr_gpr_ack_o) begin
        checks++;
        if (exp_ack_q.size() == 0) begin
          errors++;
          $display("FAIL ack_unexpected got dat %h expected no ack at %0t", spr_if.spr_gpr_dat_o, $time);
        end else begin
          logic [31:0] d;
          d = exp_ack_q.pop_front();
          if (spr_if.spr_gpr_dat_o !== d) begin
            errors++;
            $display("FAIL ack_data got %h expected %h at %0t", spr_if.spr_gpr_dat_o, d, $time);
          end
        end
      end
    end
  end

  // Release reset at drive time and walk the full 32-entry clear
  task automatic do_init();
    for (int i = 0; i < 32; i++) push_wr(5'(i), 32'h0);
    rst_n = 1'b1;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      check("init_stall", {31'b0, pipe_stall}, 32'd1);
      check("init_not_done", {31'b0, init_done}, 32'd0);
    end
    @(negedge clk);
    check("init_done", {31'b0, init_done}, 32'd1);
    check("init_stall_drop", {31'b0, pipe_stall}, 32'd0);
    tick();
  endtask

  task automatic spr_drive(input logic stb, input logic we, input logic [15:0] adr, input logic [31:0] dat);
    spr_if.spr_bus_stb_i  = stb;
    spr_if.spr_bus_we_i   = we;
    spr_if.spr_bus_addr_i = adr;
    spr_if.spr_bus_dat_i  = dat;
  endtask

  initial begin
    rst_n       = 1'b0;
    wb_we       = 1'b0;
    wb_adr      = '0;
    wb_dat      = '0;
    rf_spr_rdat = 32'h12345678;
    spr_drive(1'b0, 1'b0, 16'h0, 32'h0);
    repeat (3) tick();

    check("rst_ack", {31'b0, spr_if.spr_gpr_ack_o}, 32'd0);
    check("rst_dat", spr_if.spr_gpr_dat_o, 32'h0);
    check("rst_re", {31'b0, rf_spr_re}, 32'd0);
    check("rst_done", {31'b0, init_done}, 32'd0);
    check("rst_stall", {31'b0, pipe_stall}, 32'd1);

    // Partial init, reset at cycle 10, then a full rerun from address 0
    for (int i = 0; i < 10; i++) push_wr(5'(i), 32'h0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    tick();
    rst_n = 1'b0;
    #1;
    check("rerun_adr", {27'b0, rf_wadr}, 32'd0);
    tick();
    do_init();

    // SPR write, writeback idle
    spr_drive(1'b1, 1'b1, 16'h0403, 32'hDEADBEEF);
    push_wr(5'd3, 32'hDEADBEEF);
    exp_ack_q.push_back(32'h0);
    @(negedge clk);
    check("wr_c0_ack", {31'b0, spr_if.spr_gpr_ack_o}, 32'd0);
    check("wr_c0_we", {31'b0, rf_we}, 32'd0);
    tick();
    @(negedge clk);
    check("wr_c1_ack", {31'b0, spr_if.spr_gpr_ack_o}, 32'd1);
    check("wr_c1_we", {31'b0, rf_we}, 32'd1);
    tick();
    @(negedge clk);
    check("wr_c2_ack", {31'b0, spr_if.spr_gpr_ack_o}, 32'd0);
    check("wr_c2_we", {31'b0, rf_we}, 32'd0);
    tick();
    spr_drive(1'b0, 1'b0, 16'h0, 32'h0);
    tick();

    // SPR write starved by 6 writeback cycles
    spr_drive(1'b1, 1'b1, 16'h0405, 32'h11110005);
    tick();
    for (int j = 1; j <= 6; j++) begin
      wb_we  = 1'b1;
      wb_adr = 5'd9;
      wb_dat = 32'hA0000000 + 32'(j);
      push_wr(5'd9, 32'hA0000000 + 32'(j));
      @(negedge clk);
      check("starve_stall", {31'b0, pipe_stall}, (j >= 5) ? 32'd1 : 32'd0);
      check("starve_noack", {31'b0, spr_if.spr_gpr_ack_o}, 32'd0);
      tick();
    end
    wb_we = 1'b0;
    push_wr(5'd5, 32'h11110005);
    exp_ack_q.push_back(32'h0);
    @(negedge clk);
    check("starve_retire_stall", {31'b0, pipe_stall}, 32'd1);
    check("starve_retire_ack", {31'b0, spr_if.spr_gpr_ack_o}, 32'd1);
    tick();
    spr_drive(1'b0, 1'b0, 16'h0, 32'h0);
    @(negedge clk);
    check("starve_stall_fall", {31'b0, pipe_stall}, 32'd0);
    tick();
    tick();

    // SPR read from RAM
    spr_drive(1'b1, 1'b0, 16'h0407, 32'h0);
    exp_ack_q.push_back(32'h12345678);
    @(negedge clk);
    check("rd_re", {31'b0, rf_spr_re}, 32'd1);
    check("rd_radr", {27'b0, rf_spr_radr}, 32'd7);
    check("rd_c0_dat", spr_if.spr_gpr_dat_o, 32'h0);
    tick();
    @(negedge clk);
    check("rd_c1_re", {31'b0, rf_spr_re}, 32'd0);
    check("rd_c1_ack", {31'b0, spr_if.spr_gpr_ack_o}, 32'd1);
    tick();
    spr_drive(1'b0, 1'b0, 16'h0, 32'h0);
    tick();

    // SPR read with same-cycle writeback to r7
    spr_drive(1'b1, 1'b0, 16'h0407, 32'h0);
    wb_we  = 1'b1;
    wb_adr = 5'd7;
    wb_dat = 32'hCAFEF00D;
    push_wr(5'd7, 32'hCAFEF00D);
    exp_ack_q.push_back(32'hCAFEF00D);
    tick();
    wb_we = 1'b0;
    @(negedge clk);
    check("fwd_ack", {31'b0, spr_if.spr_gpr_ack_o}, 32'd1);
    tick();
    spr_drive(1'b0, 1'b0, 16'h0, 32'h0);
    tick();

    // Non-GPR strobe held while writeback runs
    spr_drive(1'b1, 1'b0, 16'h1100, 32'h0);
    for (int i = 0; i < 10; i++) begin
      wb_we  = i[0];
      wb_adr = 5'(i + 10);
      wb_dat = 32'hB0000000 + 32'(i);
      if (i[0]) push_wr(5'(i + 10), 32'hB0000000 + 32'(i));
      @(negedge clk);
      check("nongpr_re", {31'b0, rf_spr_re}, 32'd0);
      tick();
    end
    wb_we = 1'b0;
    spr_drive(1'b0, 1'b0, 16'h0, 32'h0);
    tick();

    // Reset while a buffered write is starved: never acked, init reruns
    spr_drive(1'b1, 1'b1, 16'h0401, 32'h00000055);
    tick();
    wb_we  = 1'b1;
    wb_adr = 5'd2;
    wb_dat = 32'h00000022;
    push_wr(5'd2, 32'h00000022);
    tick();
    rst_n = 1'b0;
    wb_we = 1'b0;
    spr_drive(1'b0, 1'b0, 16'h0, 32'h0);
    #1;
    check("midrst_ack", {31'b0, spr_if.spr_gpr_ack_o}, 32'd0);
    check("midrst_stall", {31'b0, pipe_stall}, 32'd1);
    check("midrst_done", {31'b0, init_done}, 32'd0);
    tick();
    do_init();
    repeat (3) tick();

    check("wr_queue_empty", exp_wr_q.size(), 32'd0);
    check("ack_queue_empty", exp_ack_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
